uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx_if.sv | 30 +++
 rtl/uart_frame_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if -- byte stream, response and frame-buffer signals
// of the framed UART receiver; master is the environment side.
interface uart_frame_rx_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ack;
  logic       overrun;

  modport master (
    output rx_valid, rx_byte, rx_error, tx_busy,
    output rd_addr, frame_ack,
    input  tx_start, tx_byte, frame_valid,
    input  frame_len, rd_data, overrun
  );

  modport slave (
    input  rx_valid, rx_byte, rx_error, tx_busy,
    input  rd_addr, frame_ack,
    output tx_start, tx_byte, frame_valid,
    output frame_len, rd_data, overrun
  );
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx -- SOF/LEN/payload/XOR-checksum frame receiver with hold buffer.
// Define UART_FRAME_RESP_EN to send ACK/NAK bytes back over the UART.
module uart_frame_rx #(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 24000
) (
  input logic            clk,
  input logic            rst_n,
  uart_frame_rx_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [8:0] MAXL = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    RESP,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [7:0]    len_q;
  logic [7:0]    idx_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] tmo_q;
  logic          overrun_q;
  logic [7:0]    mem [MAX_LEN];

  logic byte_ok;
  logic is_sof;
  logic len_bad;
  logic last;
  logic csum_ok;
  logic tmo_hit;
  logic in_frame;

  assign byte_ok  = bus.rx_valid & ~bus.rx_error;
  assign is_sof   = (bus.rx_byte == SOF_BYTE);
  assign len_bad  = (bus.rx_byte == 8'd0) ||
                    ({1'b0, bus.rx_byte} > MAXL);
  assign last     = (idx_q == len_q - 8'd1);
  assign csum_ok  = (bus.rx_byte == csum_q);
  assign tmo_hit  = ~bus.rx_valid && (tmo_q == TMO_LAST);
  assign in_frame = (state == LEN) || (state == DATA) ||
                    (state == CSUM);

`ifdef UART_FRAME_RESP_EN
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic [7:0] resp_q;

  // Latch the reply code when a bad LEN or the checksum byte arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= 8'h00;
    end else if (state == LEN && byte_ok && len_bad) begin
      resp_q <= NAK;
    end else if (state == CSUM && byte_ok) begin
      resp_q <= csum_ok ? ACK : NAK;
    end
  end

  assign bus.tx_start = (state == RESP);
  assign bus.tx_byte  = (state == RESP) ? resp_q : 8'h00;
`else
  logic unused_busy;
  assign unused_busy  = bus.tx_busy;
  assign bus.tx_start = 1'b0;
  assign bus.tx_byte  = 8'h00;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode; rx_error wins over rx_valid inside a frame.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (byte_ok && is_sof) state_d = LEN;
      end
      LEN: begin
        if (bus.rx_error || tmo_hit) begin
          state_d = IDLE;
        end else if (bus.rx_valid) begin
`ifdef UART_FRAME_RESP_EN
          state_d = len_bad ? RESP : DATA;
`else
          state_d = len_bad ? IDLE : DATA;
`endif
        end
      end
      DATA: begin
        if (bus.rx_error || tmo_hit) begin
          state_d = IDLE;
        end else if (bus.rx_valid && last) begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (bus.rx_error || tmo_hit) begin
          state_d = IDLE;
        end else if (bus.rx_valid) begin
`ifdef UART_FRAME_RESP_EN
          state_d = RESP;
`else
          state_d = csum_ok ? HOLD : IDLE;
`endif
        end
      end
      RESP: begin
`ifdef UART_FRAME_RESP_EN
        if (bus.tx_busy) begin
          state_d = (resp_q == ACK) ? HOLD : IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      HOLD: begin
        if (bus.frame_ack) begin
          state_d = (byte_ok && is_sof) ? LEN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Length, index, checksum, idle timer and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      csum_q    <= 8'd0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.rx_valid &&
                   ((state == RESP) ||
                    (state == HOLD && !bus.frame_ack));
      if (in_frame && !bus.rx_valid) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
      unique case (state)
        LEN: begin
          if (byte_ok && !len_bad) begin
            len_q  <= bus.rx_byte;
            csum_q <= bus.rx_byte;
            idx_q  <= 8'd0;
          end
        end
        DATA: begin
          if (byte_ok) begin
            idx_q  <= idx_q + 8'd1;
            csum_q <= csum_q ^ bus.rx_byte;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Payload buffer; only written while collecting DATA bytes.
  always_ff @(posedge clk) begin
    if (state == DATA && byte_ok) begin
      mem[idx_q[AW-1:0]] <= bus.rx_byte;
    end
  end

  assign bus.rd_data = ({1'b0, bus.rd_addr} < MAXL) ?
                       mem[bus.rd_addr[AW-1:0]] : 8'h00;
  assign bus.frame_valid = (state == HOLD);
  assign bus.frame_len   = (state == HOLD) ? len_q : 8'h00;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx -- directed checks of uart_frame_rx framing,
// responses, hold buffer, overrun, timeout, rx_error and reset.
module tb_uart_frame_rx;

  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  uart_frame_rx_if bus ();

  uart_frame_rx #(
    .MAX_LEN    (16),
    .SOF_BYTE   (8'hA5),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Called right after the checksum / bad-LEN byte has been taken.
  task automatic resp(input string tag, input logic [7:0] code);
`ifdef UART_FRAME_RESP_EN
    chk({tag, "_tx_start_on"}, {7'd0, bus.tx_start}, 8'd1);
    chk({tag, "_tx_byte"}, bus.tx_byte, code);
    @(negedge clk);
    chk({tag, "_tx_start_hold"}, {7'd0, bus.tx_start}, 8'd1);
    chk({tag, "_tx_byte_hold"}, bus.tx_byte, code);
    chk({tag, "_fv_in_resp"}, {7'd0, bus.frame_valid}, 8'd0);
    bus.tx_busy = 1'b1;
    @(negedge clk);
    bus.tx_busy = 1'b0;
    chk({tag, "_tx_start_off"}, {7'd0, bus.tx_start}, 8'd0);
`else
    chk({tag, "_tx_start"}, {7'd0, bus.tx_start}, 8'd0);
    chk({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
`endif
    chk({tag, "_frame_valid"}, {7'd0, bus.frame_valid},
        {7'd0, code == 8'h06});
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    bus.rd_addr = a;
    #1;
    chk($sformatf("rd_data[%0d]", a), bus.rd_data, e);
  endtask

  task automatic release_frame(input string tag);
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    chk({tag, "_released"}, {7'd0, bus.frame_valid}, 8'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tx_start"}, {7'd0, bus.tx_start}, 8'd0);
    chk({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
    chk({tag, "_frame_valid"}, {7'd0, bus.frame_valid}, 8'd0);
    chk({tag, "_frame_len"}, bus.frame_len, 8'h00);
    chk({tag, "_overrun"}, {7'd0, bus.overrun}, 8'd0);
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.rx_error  = 1'b0;
    bus.tx_busy   = 1'b0;
    bus.rd_addr   = 8'h00;
    bus.frame_ack = 1'b0;

    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Good 3-byte frame: 03^11^22^33 = 03.
    send(8'hA5); send(8'h03); send(8'h11);
    send(8'h22); send(8'h33); send(8'h03);
    resp("ack3", 8'h06);
    chk("ack3_len", bus.frame_len, 8'd3);
    rd(8'd0, 8'h11);
    rd(8'd1, 8'h22);
    rd(8'd2, 8'h33);

    // Stray byte while holding: dropped, frame intact.
    send(8'h55);
    chk("ovr_pulse", {7'd0, bus.overrun}, 8'd1);
    chk("ovr_fv", {7'd0, bus.frame_valid}, 8'd1);
    @(negedge clk);
    chk("ovr_end", {7'd0, bus.overrun}, 8'd0);
    chk("ovr_len", bus.frame_len, 8'd3);
    rd(8'd1, 8'h22);

    // SOF together with frame_ack starts the next frame.
    @(negedge clk);
    bus.rx_valid  = 1'b1;
    bus.rx_byte   = 8'hA5;
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus.frame_ack = 1'b0;
    chk("coinc_fv", {7'd0, bus.frame_valid}, 8'd0);
    chk("coinc_ovr", {7'd0, bus.overrun}, 8'd0);
    // 02^10^20 = 32, so 00 is a mismatch.
    send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    resp("badcs", 8'h15);
    chk("badcs_len", bus.frame_len, 8'h00);

    // Checksum 01 for the 3-byte frame is also a mismatch.
    send(8'hA5); send(8'h03); send(8'h11);
    send(8'h22); send(8'h33); send(8'h01);
    resp("badcs3", 8'h15);

    // Zero and oversize LEN.
    send(8'hA5); send(8'h00);
    resp("len0", 8'h15);
    send(8'hA5); send(8'h11);
    resp("len17", 8'h15);
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    resp("after_len", 8'h06);
    chk("after_len_len", bus.frame_len, 8'd1);
    rd(8'd0, 8'h5A);
    release_frame("after_len");

    // Maximum length: payload 01..10, checksum 10^(01..10) = 00.
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    send(8'h00);
    resp("max", 8'h06);
    chk("max_len", bus.frame_len, 8'd16);
    rd(8'd0, 8'h01);
    rd(8'd15, 8'h10);
    release_frame("max");

    // TMO-1 idle cycles between bytes is still in time.
    send(8'hA5); send(8'h02); send(8'h10);
    repeat (TMO - 2) @(negedge clk);
    send(8'h20); send(8'h32);
    resp("tmo_keep", 8'h06);
    chk("tmo_keep_len", bus.frame_len, 8'd2);
    rd(8'd1, 8'h20);
    release_frame("tmo_keep");

    // TMO idle cycles abort the frame silently.
    send(8'hA5); send(8'h02); send(8'h10);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_silent", {7'd0, bus.tx_start}, 8'd0);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    resp("tmo_abort", 8'h06);
    chk("tmo_abort_len", bus.frame_len, 8'd1);
    rd(8'd0, 8'h7E);
    release_frame("tmo_abort");

    // frame_ack outside HOLD has no effect.
    send(8'hA5); send(8'h01);
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    send(8'h44); send(8'h45);
    resp("ack_ign", 8'h06);
    chk("ack_ign_len", bus.frame_len, 8'd1);
    release_frame("ack_ign");

    // rx_error beats a coincident rx_valid and aborts.
    send(8'hA5); send(8'h02);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_error = 1'b1;
    bus.rx_byte  = 8'h10;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
    chk("err_silent", {7'd0, bus.tx_start}, 8'd0);
    send(8'hA5); send(8'h01); send(8'h33); send(8'h32);
    resp("err", 8'h06);
    chk("err_len", bus.frame_len, 8'd1);
    rd(8'd0, 8'h33);
    release_frame("err");

    // Reset while holding a frame drops it at once.
    send(8'hA5); send(8'h01); send(8'h66); send(8'h67);
    resp("rst_hold", 8'h06);
    chk("rst_hold_pre", bus.frame_len, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-DATA: rest of the old frame is ignored.
    send(8'hA5); send(8'h03); send(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_data");
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h22); send(8'h33); send(8'h01);
    chk("rst_data_tx", {7'd0, bus.tx_start}, 8'd0);
    chk("rst_data_fv", {7'd0, bus.frame_valid}, 8'd0);
    @(negedge clk);
    chk("rst_data_tx2", {7'd0, bus.tx_start}, 8'd0);
    send(8'hA5); send(8'h01); send(8'h12); send(8'h13);
    resp("rst_after", 8'h06);
    rd(8'd0, 8'h12);
    release_frame("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
